uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares the single UART transmit path of `uart_protocol` between `NUM_REQ` requesters. Each requester asks for a frame of 1..`MAX_BURST` bytes. The scheduler grants one requester at a time and holds the grant for the whole frame, so bytes from different requesters never interleave. Bytes from the granted requester are forwarded into the TX FIFO under FIFO back-pressure. A watchdog aborts frames whose owner stalls.

---
 rtl/uart_tx_scheduler_pkg.sv | 11 +
 rtl/uart_tx_scheduler_arb.sv | 36 +++
 rtl/uart_tx_scheduler.sv | 119 +++++++++++
 tb/tb_uart_tx_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART TX scheduler: FSM state encoding and default byte width.
package uart_tx_scheduler_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  localparam int DATA_SIZE_DEF = 8;

endpackage

// File: rtl/uart_tx_scheduler_arb.sv
// Combinational round-robin arbiter: the search starts one slot after the previous owner
// and wraps around by scanning a doubled copy of the request vector.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [ID_W:0]        w_idx;
  logic [ID_W:0]        w_wrap;
  logic                 w_found;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_wrap  = '0;
    w_dbl   = {req, req};
    for (int j = 0; j < NUM_REQ; j++) begin
      w_idx = (ID_W+1)'(last) + (ID_W+1)'(j) + 1'b1;
      if (!w_found && w_dbl[w_idx]) begin
        w_found = 1'b1;
        w_wrap  = (w_idx >= (ID_W+1)'(NUM_REQ)) ? w_idx - (ID_W+1)'(NUM_REQ) : w_idx;
        gnt_id  = w_wrap[ID_W-1:0];
      end
    end
    if (w_found) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares the UART TX FIFO write port between NUM_REQ requesters, one whole frame at a time,
// with a watchdog that drops frames whose owner stops supplying bytes.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = $clog2(MAX_BURST+1),
  parameter int TIMEOUT   = 1024,
  parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*LEN_W-1:0]       req_len,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             grant,
  input  logic                           tx_fifo_full,
  output logic                           tx_wr_en,
  output logic [DATA_SIZE-1:0]           tx_wr_data,
  output logic                           busy,
  output logic                           abort,
  output logic [ID_W-1:0]                abort_id
);

  localparam int WD_W = $clog2(TIMEOUT);

  state_t              r_state, w_next;
  logic [NUM_REQ-1:0]  r_grant;
  logic [ID_W-1:0]     r_gid, r_last, r_abort_id;
  logic [LEN_W-1:0]    r_cnt;
  logic [WD_W-1:0]     r_wd;
  logic                r_abort;

  logic [NUM_REQ-1:0]  w_arb_gnt;
  logic [ID_W-1:0]     w_arb_id;
  logic                w_xfer, w_valid_g, w_beat, w_last_beat, w_timeout;

  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req    (req),
    .last   (r_last),
    .gnt    (w_arb_gnt),
    .gnt_id (w_arb_id)
  );

  assign w_xfer      = (r_state == ST_XFER);
  assign w_valid_g   = req_valid[r_gid];
  assign w_beat      = w_xfer & w_valid_g & ~tx_fifo_full;
  assign w_last_beat = w_beat & (r_cnt == LEN_W'(1));
  // A final beat and the watchdog threshold cannot collide: the watchdog only fires on a no-valid cycle.
  assign w_timeout   = w_xfer & ~w_valid_g & (r_wd == WD_W'(TIMEOUT-2));

  assign busy       = w_xfer;
  assign grant      = r_grant;
  assign req_ready  = (w_xfer && !tx_fifo_full) ? r_grant : '0;
  assign tx_wr_en   = w_beat;
  assign tx_wr_data = w_xfer ? req_data[r_gid*DATA_SIZE +: DATA_SIZE] : '0;
  assign abort      = r_abort;
  assign abort_id   = r_abort_id;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (|req) w_next = ST_XFER;
      ST_XFER: if (w_last_beat || w_timeout) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant    <= '0;
      r_gid      <= '0;
      r_last     <= ID_W'(NUM_REQ-1);
      r_cnt      <= '0;
      r_wd       <= '0;
      r_abort    <= 1'b0;
      r_abort_id <= '0;
    end else begin
      r_abort <= w_timeout;
      if (r_state == ST_IDLE) begin
        if (|req) begin
          r_grant <= w_arb_gnt;
          r_gid   <= w_arb_id;
          r_cnt   <= eff_len(req_len[w_arb_id*LEN_W +: LEN_W]);
          r_wd    <= '0;
        end
      end else if (w_beat) begin
        r_cnt <= r_cnt - 1'b1;
        r_wd  <= '0;
        if (w_last_beat) begin
          r_grant <= '0;
          r_last  <= r_gid;
        end
      end else if (w_timeout) begin
        r_abort_id <= r_gid;
        r_grant    <= '0;
        r_last     <= r_gid;
        r_cnt      <= '0;
        r_wd       <= '0;
      end else if (!w_valid_g) begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a byte scoreboard fed when frames are requested
// and drained as the DUT writes the TX FIFO.
module tb_uart_tx_scheduler;

  localparam int DATA_SIZE = 8;
  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 16;
  localparam int LEN_W     = $clog2(MAX_BURST+1);
  localparam int TIMEOUT   = 1024;

  logic                         clk = 1'b0;
  logic                         reset_n;
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*LEN_W-1:0]     req_len;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           grant;
  logic                         tx_fifo_full;
  logic                         tx_wr_en;
  logic [DATA_SIZE-1:0]         tx_wr_data;
  logic                         busy;
  logic                         abort;
  logic [1:0]                   abort_id;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .DATA_SIZE(DATA_SIZE), .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_len(req_len), .req_data(req_data),
    .req_valid(req_valid), .req_ready(req_ready), .grant(grant), .tx_fifo_full(tx_fifo_full),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .busy(busy), .abort(abort), .abort_id(abort_id)
  );

  // Each requester emits {slot, running byte count}; the count advances only on an accepted byte.
  logic [7:0] src_cnt [NUM_REQ];
  initial for (int i = 0; i < NUM_REQ; i++) src_cnt[i] = '0;
  always @(posedge clk)
    for (int i = 0; i < NUM_REQ; i++)
      if (req_valid[i] && req_ready[i]) src_cnt[i] <= src_cnt[i] + 8'd1;
  always_comb
    for (int i = 0; i < NUM_REQ; i++)
      req_data[i*DATA_SIZE +: DATA_SIZE] = {3'(i), src_cnt[i][4:0]};

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         last_wr_cyc = -1;
  int         abort_cyc = -1;
  int         run_len = 0;
  int         max_run = 0;
  int         n_bytes = 0;
  logic [7:0] exp_q[$];
  logic [7:0] next_exp [NUM_REQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    cyc++;
    if (reset_n && busy) chk("ready_only_granted", 32'(req_ready & ~grant), 32'd0);
    if (abort) abort_cyc = cyc;
    if (tx_wr_en) begin
      n_bytes++;
      last_wr_cyc = cyc;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_errors++;
          $error("FAIL unexpected_byte: observed 0x%0h expected no write", tx_wr_data);
        end
      end else begin
        chk("tx_byte", 32'(tx_wr_data), 32'(exp_q.pop_front()));
      end
    end else begin
      run_len = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({3'(id), next_exp[id][4:0]});
      next_exp[id] = next_exp[id] + 8'd1;
    end
  endtask

  task automatic set_len(input int id, input int len);
    req_len[id*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  task automatic wait_grant(input int id, input string tag, input bit need_gap);
    bit saw_zero = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (grant == 4'(1 << id)) break;
      if (grant == '0) saw_zero = 1'b1;
      tick();
    end
    chk(tag, 32'(grant), 32'(1 << id));
    if (need_gap) chk({tag, "_gap"}, 32'(saw_zero), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 400; k++) begin
      if (!busy) break;
      tick();
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int nb0;
    for (int i = 0; i < NUM_REQ; i++) next_exp[i] = '0;
    reset_n      = 1'b0;
    req          = '0;
    req_len      = '0;
    req_valid    = '0;
    tx_fifo_full = 1'b0;
    repeat (3) tick();

    chk("rst_grant",    32'(grant),      32'd0);
    chk("rst_busy",     32'(busy),       32'd0);
    chk("rst_ready",    32'(req_ready),  32'd0);
    chk("rst_wr_en",    32'(tx_wr_en),   32'd0);
    chk("rst_wr_data",  32'(tx_wr_data), 32'd0);
    chk("rst_abort",    32'(abort),      32'd0);
    chk("rst_abort_id", 32'(abort_id),   32'd0);
    reset_n = 1'b1;
    tick();

    // Reset priority: all four request, lengths 2/1/3/1, expect strict order 0,1,2,3.
    nb0 = n_bytes;
    set_len(0, 2); set_len(1, 1); set_len(2, 3); set_len(3, 1);
    push_exp(0, 2); push_exp(1, 1); push_exp(2, 3); push_exp(3, 1);
    req_valid = 4'b1111;
    req       = 4'b1111;
    wait_grant(0, "order_g0", 1'b0); req[0] = 1'b0;
    wait_grant(1, "order_g1", 1'b1); req[1] = 1'b0;
    wait_grant(2, "order_g2", 1'b1); req[2] = 1'b0;
    wait_grant(3, "order_g3", 1'b1); req[3] = 1'b0;
    wait_idle("order_idle");
    tick();
    chk("order_bytes", 32'(n_bytes - nb0), 32'd7);
    chk("order_drained", 32'(exp_q.size()), 32'd0);

    // Rotation: once 2 has finished, 0 must beat a re-requesting 2.
    set_len(2, 1); push_exp(2, 1);
    req = 4'b0100;
    wait_grant(2, "rot_g2", 1'b0);
    set_len(0, 1); push_exp(0, 1); push_exp(2, 1);
    req = 4'b0101;
    wait_grant(0, "rot_g0", 1'b1); req[0] = 1'b0;
    wait_grant(2, "rot_g2b", 1'b1); req[2] = 1'b0;
    wait_idle("rot_idle");
    chk("rot_drained", 32'(exp_q.size()), 32'd0);

    // Back-pressure: 50 full cycles mid-frame must neither write nor abort.
    set_len(1, 6); push_exp(1, 6);
    req = 4'b0010;
    wait_grant(1, "bp_g1", 1'b0); req = '0;
    tick();
    tx_fifo_full = 1'b1;
    for (int k = 0; k < 50; k++) begin
      #1;
      chk("bp_no_wr", 32'(tx_wr_en), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    tx_fifo_full = 1'b0;
    wait_idle("bp_idle");
    chk("bp_no_abort", 32'(abort_cyc), 32'hFFFF_FFFF);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Timeout: owner 1 sends 2 of 5 bytes then stalls; requester 2 waits behind it.
    set_len(1, 5); push_exp(1, 2);
    req = 4'b0010;
    wait_grant(1, "to_g1", 1'b0);
    set_len(2, 1); push_exp(2, 1);
    req = 4'b0100;
    tick();
    tick();
    req_valid[1] = 1'b0;
    for (int k = 0; k < TIMEOUT + 50; k++) begin
      if (abort_cyc >= 0) break;
      tick();
    end
    chk("to_abort_seen", 32'(abort_cyc >= 0), 32'd1);
    chk("to_abort_delay", 32'(abort_cyc - last_wr_cyc), 32'(TIMEOUT));
    chk("to_abort_id", 32'(abort_id), 32'd1);
    chk("to_abort_pulse", 32'(abort), 32'd0);
    wait_grant(2, "to_next_g2", 1'b0); req = '0;
    req_valid = 4'b1111;
    wait_idle("to_idle");
    chk("to_drained", 32'(exp_q.size()), 32'd0);
    chk("to_abort_id_hold", 32'(abort_id), 32'd1);

    // Length 0 behaves as a one-byte frame.
    set_len(3, 0); push_exp(3, 1);
    req = 4'b1000;
    wait_grant(3, "len0_g3", 1'b0); req = '0;
    wait_idle("len0_idle");
    tick();
    chk("len0_drained", 32'(exp_q.size()), 32'd0);

    // Full burst of MAX_BURST bytes back-to-back.
    set_len(0, MAX_BURST); push_exp(0, MAX_BURST);
    req = 4'b0001;
    wait_grant(0, "burst_g0", 1'b0); req = '0;
    wait_idle("burst_idle");
    tick();
    chk("burst_run", 32'(max_run), 32'(MAX_BURST));
    chk("burst_drained", 32'(exp_q.size()), 32'd0);

    // Reset during beat 3 of an 8-byte frame from requester 1.
    set_len(1, 8); push_exp(1, 2);
    req = 4'b0010;
    wait_grant(1, "rstmid_g1", 1'b0); req = '0;
    tick();
    tick();
    chk("rstmid_pre_wr", 32'(tx_wr_en), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rstmid_wr_en", 32'(tx_wr_en), 32'd0);
    chk("rstmid_grant", 32'(grant), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    tick();
    chk("rstmid_no_abort", 32'(abort), 32'd0);
    reset_n = 1'b1;
    tick();
    set_len(0, 1); set_len(1, 1);
    push_exp(0, 1); push_exp(1, 1);
    req = 4'b0011;
    wait_grant(0, "rstmid_prio0", 1'b0); req[0] = 1'b0;
    wait_grant(1, "rstmid_then1", 1'b1); req[1] = 1'b0;
    wait_idle("rstmid_idle");
    tick();
    chk("rstmid_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
